// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: state encodings,
// default geometry and the derived per-operation cycle count.
`ifndef SERIAL_SUBTRACTOR_PKG_SV
`define SERIAL_SUBTRACTOR_PKG_SV

`define SERIAL_SUB_N(w, d) ((w) / (d))

package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 1;

    // Cycles per operation; DIGIT must divide WIDTH evenly.
    function automatic int num_digits(input int width, input int digit);
        return `SERIAL_SUB_N(width, digit);
    endfunction

endpackage

`endif

// File: rtl/serial_subtractor_digit_subtractor.sv
// Combinational DIGIT-wide subtract with borrow: {bo, d} = x - y - bi.
module digit_subtractor #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] full;

    // One extra bit catches the borrow as the sign of the widened difference.
    assign full = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
    assign d    = full[DIGIT-1:0];
    assign bo   = full[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b - bin, DIGIT bits per clock,
// LSB first, with a start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output state_t           state
);

    // Handshake: start is accepted on any edge where the block is in IDLE or
    // DONE; busy is high from that edge until the completing edge, and done
    // is high for exactly the one cycle after completion.

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = $clog2(N) + 1;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0]       d;
    logic                   bo;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   accept;
    logic                   last;

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .x  (a_sh[DIGIT-1:0]),
        .y  (b_sh[DIGIT-1:0]),
        .bi (borrow),
        .d  (d),
        .bo (bo)
    );

    // New digit enters at the MSB end so the result lands aligned after N steps.
    assign res_cat  = {d, res};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                borrow <= bin;
                cnt    <= '0;
            end else if (state_q == RUN) begin
                a_sh   <= a_sh >> DIGIT;
                b_sh   <= b_sh >> DIGIT;
                borrow <= bo;
                res    <= res_next;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    diff <= res_next;
                    bout <= bo;
                end
            end
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign state = state_q;

endmodule
